// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read (latency 1).
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  // Pointer wrap relies on DEPTH filling the pointer range exactly.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : gBadAf
    $fatal(1, "sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : gBadAe
    $fatal(1, "sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wrOk;
  logic             w_rdOk;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wrOk  = w_en & ~w_full;
  assign w_rdOk  = r_en & ~w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wrOk) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdOk) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_wrOk, w_rdOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (r_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue is always presented; zero when nothing is stored.
  assign dout = w_empty ? '0 : r_mem[r_rdPtr];
`else
  logic [WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rdOk) begin
      r_dout <= r_mem[r_rdPtr];
    end
  end

  assign dout = r_dout;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
// Expected dout values follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic [7:0] din;
  logic       r_en;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  sync_fifo_param #(
    .WIDTH   (8),
    .DEPTH   (8),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_en        (w_en),
    .din         (din),
    .r_en        (r_en),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] expDout;

    rst  = 1'b1;
    w_en = 1'b0;
    r_en = 1'b0;
    din  = 8'h00;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset count",        32'(count),        32'd0);
    checkOutput("reset empty",        32'(empty),        32'd1);
    checkOutput("reset full",         32'(full),         32'd0);
    checkOutput("reset almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("reset almost_full",  32'(almost_full),  32'd0);
    checkOutput("reset dout",         32'(dout),         32'h00);
    checkOutput("reset overflow",     32'(overflow),     32'd0);
    checkOutput("reset underflow",    32'(underflow),    32'd0);

    // Fill with 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1;
      din  = 8'(8'h10 + i);
      applyStimulus();
      checkOutput($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
      checkOutput($sformatf("fill%0d almost_full", i), 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill%0d almost_empty", i), 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill%0d full", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end
    w_en = 1'b0;

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      r_en = 1'b1;
      applyStimulus();
`ifdef SYNC_FIFO_FWFT_EN
      expDout = (i < 7) ? 8'(8'h11 + i) : 8'h00;
`else
      expDout = 8'(8'h10 + i);
`endif
      checkOutput($sformatf("drain%0d dout", i), 32'(dout), 32'(expDout));
      checkOutput($sformatf("drain%0d count", i), 32'(count), 32'(7 - i));
    end
    r_en = 1'b0;
    checkOutput("drained empty", 32'(empty), 32'd1);

    // Refill with 0x20..0x27, then overflow with simultaneous read.
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1;
      din  = 8'(8'h20 + i);
      applyStimulus();
    end
    checkOutput("refill full", 32'(full), 32'd1);
    w_en = 1'b1;
    r_en = 1'b1;
    din  = 8'hAA;
    applyStimulus();
    w_en = 1'b0;
    checkOutput("ovf count",    32'(count),    32'd7);
    checkOutput("ovf overflow", 32'(overflow), 32'd1);
    checkOutput("ovf full",     32'(full),     32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("ovf dout", 32'(dout), 32'h21);
`else
    checkOutput("ovf dout", 32'(dout), 32'h20);
`endif
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
`ifdef SYNC_FIFO_FWFT_EN
      expDout = (i < 6) ? 8'(8'h22 + i) : 8'h00;
`else
      expDout = 8'(8'h21 + i);
`endif
      checkOutput($sformatf("ovfdrain%0d dout", i), 32'(dout), 32'(expDout));
    end
    r_en = 1'b0;
    checkOutput("ovfdrain empty",     32'(empty),     32'd1);
    checkOutput("ovf sticky",         32'(overflow),  32'd1);
    checkOutput("ovf no underflow",   32'(underflow), 32'd0);

    // Underflow with simultaneous write of 0x55 into an empty FIFO.
    w_en = 1'b1;
    r_en = 1'b1;
    din  = 8'h55;
    applyStimulus();
    w_en = 1'b0;
    r_en = 1'b0;
    checkOutput("unf count",     32'(count),     32'd1);
    checkOutput("unf underflow", 32'(underflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("unf dout", 32'(dout), 32'h55);
`else
    checkOutput("unf dout", 32'(dout), 32'h27);
`endif
    r_en = 1'b1;
    applyStimulus();
    r_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("unf read dout", 32'(dout), 32'h00);
`else
    checkOutput("unf read dout", 32'(dout), 32'h55);
`endif
    checkOutput("unf read count",  32'(count),    32'd0);
    checkOutput("unf sticky",      32'(underflow), 32'd1);
    checkOutput("ovf still set",   32'(overflow),  32'd1);

    // Preload three words, then stream 20 concurrent read+write cycles.
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1;
      din  = 8'(8'h60 + i);
      applyStimulus();
    end
    for (int i = 0; i < 20; i++) begin
      w_en = 1'b1;
      r_en = 1'b1;
      din  = 8'(8'h63 + i);
      applyStimulus();
`ifdef SYNC_FIFO_FWFT_EN
      expDout = 8'(8'h61 + i);
`else
      expDout = 8'(8'h60 + i);
`endif
      checkOutput($sformatf("wrap%0d dout", i), 32'(dout), 32'(expDout));
      checkOutput($sformatf("wrap%0d count", i), 32'(count), 32'd3);
    end
    w_en = 1'b0;
    r_en = 1'b0;

    // Reset with a write pending: the write must be discarded and sticky flags cleared.
    rst  = 1'b1;
    w_en = 1'b1;
    din  = 8'h99;
    applyStimulus();
    rst  = 1'b0;
    w_en = 1'b0;
    checkOutput("rst2 count",     32'(count),     32'd0);
    checkOutput("rst2 overflow",  32'(overflow),  32'd0);
    checkOutput("rst2 underflow", 32'(underflow), 32'd0);
    checkOutput("rst2 dout",      32'(dout),      32'h00);
    applyStimulus();
    checkOutput("rst2 idle empty", 32'(empty), 32'd1);

    // Single word 0x3C: visible without r_en in FWFT, after r_en otherwise.
    w_en = 1'b1;
    din  = 8'h3C;
    applyStimulus();
    w_en = 1'b0;
    applyStimulus();
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("head dout", 32'(dout), 32'h3C);
`else
    checkOutput("head dout", 32'(dout), 32'h00);
`endif
    r_en = 1'b1;
    applyStimulus();
    r_en = 1'b0;
    checkOutput("head empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("head pop dout", 32'(dout), 32'h00);
`else
    checkOutput("head pop dout", 32'(dout), 32'h3C);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
